// File: rtl/safe_keypad_arbiter_if.sv
// safe_keypad_arbiter_if: requester-side and lock-core-side signals of the
// keypad arbiter. master = environment/bench, slave = the arbiter.
interface safe_keypad_arbiter_if;
   logic [1:0] req;
   logic [3:0] btn0;
   logic       btn0_vld;
   logic [3:0] btn1;
   logic       btn1_vld;
   logic [1:0] ms_req;
   logic       core_locked;
   logic [3:0] core_btn;
   logic       core_ms;
   logic [1:0] gnt;
   logic       timeout;
   logic       drop;

   modport master (
      output req, btn0, btn0_vld, btn1, btn1_vld, ms_req, core_locked,
      input  core_btn, core_ms, gnt, timeout, drop
   );

   modport slave (
      input  req, btn0, btn0_vld, btn1, btn1_vld, ms_req, core_locked,
      output core_btn, core_ms, gnt, timeout, drop
   );
endinterface

// File: rtl/safe_keypad_arbiter.sv
// safe_keypad_arbiter: grants exclusive lock-core sessions to two keypad
// requesters (0 = front panel, 1 = remote), forwards single-cycle button
// codes, and frees the session on release, lockout or inactivity timeout.
// Optional feature macro: REMOTE_MS_EN (requester 1 may drive core_ms).
module safe_keypad_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter int unsigned GAP_CYC     = 4
) (
   input logic                  clk,
   input logic                  rst,
   safe_keypad_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_SPACE = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam logic [3:0] BTN_NONE = 4'b1111;

   logic [1:0]       r_state, w_state_nxt;
   logic [1:0]       r_gnt, w_gnt_nxt;
   logic [3:0]       r_core_btn, w_btn_nxt;
   logic             r_core_ms, w_ms_nxt;
   logic             r_timeout, w_to_nxt;
   logic             r_drop, w_drop_nxt;
   logic             r_rr, w_rr_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [GAP_W-1:0] r_gap, w_gap_nxt;

   logic             w_win;
   logic [3:0]       w_sel_btn;
   logic             w_sel_vld;
   logic             w_press;
   logic             w_release;

   // Granted requester's press: a strobe carrying a real (non-idle) code.
   assign w_sel_btn = r_gnt[1] ? bus.btn1 : bus.btn0;
   assign w_sel_vld = r_gnt[1] ? bus.btn1_vld : bus.btn0_vld;
   assign w_press   = w_sel_vld && (w_sel_btn != BTN_NONE);
   // Lockout during a session ends it exactly like a release.
   assign w_release = ((r_gnt & bus.req) == 2'b00) || bus.core_locked;

`ifdef REMOTE_MS_EN
   assign w_ms_nxt = |(w_gnt_nxt & bus.ms_req);
`else
   assign w_ms_nxt = (w_gnt_nxt == 2'b01) && bus.ms_req[0];
   logic w_unused_ms1;
   assign w_unused_ms1 = bus.ms_req[1];
`endif

   // Next-state logic for session FSM, counters and output pulses.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_btn_nxt   = BTN_NONE;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_rr_nxt    = r_rr;
      w_to_nxt    = 1'b0;
      w_drop_nxt  = 1'b0;
      w_win       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_gnt_nxt = 2'b00;
            if (!bus.core_locked && (bus.req != 2'b00)) begin
               case (bus.req)
                  2'b01:   w_win = 1'b0;
                  2'b10:   w_win = 1'b1;
                  default: w_win = r_rr;
               endcase
               // Pointer moves past every winner, so a tie after a lone grant
               // goes to the requester that was not just served.
               w_rr_nxt    = ~w_win;
               w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
               w_cnt_nxt   = '0;
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT, S_SPACE: begin
            if (w_release || (r_cnt == CNT_LAST)) begin
               w_to_nxt    = !w_release;
               w_drop_nxt  = w_press;
               w_gnt_nxt   = 2'b00;
               w_gap_nxt   = '0;
               w_state_nxt = S_GAP;
            end else if ((r_state == S_GRANT) && w_press) begin
               w_btn_nxt   = w_sel_btn;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SPACE;
            end else begin
               w_drop_nxt  = (r_state == S_SPACE) && w_press;
               if (r_cnt != CNT_MAX) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
               w_state_nxt = S_GRANT;
            end
         end
         S_GAP: begin
            w_gnt_nxt = 2'b00;
            if (r_gap == GAP_LAST) begin
               w_gap_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         default: begin
            w_gnt_nxt   = 2'b00;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Register state and all outputs; synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= 2'b00;
         r_core_btn <= BTN_NONE;
         r_core_ms  <= 1'b0;
         r_timeout  <= 1'b0;
         r_drop     <= 1'b0;
         r_rr       <= 1'b0;
         r_cnt      <= '0;
         r_gap      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_core_btn <= w_btn_nxt;
         r_core_ms  <= w_ms_nxt;
         r_timeout  <= w_to_nxt;
         r_drop     <= w_drop_nxt;
         r_rr       <= w_rr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_gap      <= w_gap_nxt;
      end
   end

   assign bus.core_btn = r_core_btn;
   assign bus.core_ms  = r_core_ms;
   assign bus.gnt      = r_gnt;
   assign bus.timeout  = r_timeout;
   assign bus.drop     = r_drop;
endmodule

// File: tb/tb_safe_keypad_arbiter.sv
// tb_safe_keypad_arbiter: directed self-checking bench for safe_keypad_arbiter
// built with TIMEOUT_CYC=8, GAP_CYC=4. Honours REMOTE_MS_EN for core_ms.
module tb_safe_keypad_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   safe_keypad_arbiter_if ifc ();

   safe_keypad_arbiter #(.TIMEOUT_CYC(8), .GAP_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      ifc.req         = 2'b00;
      ifc.btn0        = 4'b1111;
      ifc.btn0_vld    = 1'b0;
      ifc.btn1        = 4'b1111;
      ifc.btn1_vld    = 1'b0;
      ifc.ms_req      = 2'b00;
      ifc.core_locked = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      ifc.req = 2'b11;
      tick();
      tick();
      checks++; if (ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL rst_core_btn: got %b expected %b", ifc.core_btn, 4'b1111); end
      checks++; if (ifc.core_ms !== 1'b0) begin errors++; $display("FAIL rst_core_ms: got %b expected %b", ifc.core_ms, 1'b0); end
      checks++; if (ifc.gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected %b", ifc.gnt, 2'b00); end
      checks++; if (ifc.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected %b", ifc.timeout, 1'b0); end
      checks++; if (ifc.drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b expected %b", ifc.drop, 1'b0); end
      rst = 1'b0;
   endtask

   task automatic test_single_press;
      do_reset();
      tick();
      ifc.req = 2'b01;
      tick();
      checks++; if (ifc.gnt !== 2'b01) begin errors++; $display("FAIL sp_gnt: got %b expected %b", ifc.gnt, 2'b01); end
      tick();
      ifc.btn0 = 4'b1110; ifc.btn0_vld = 1'b1;
      tick();
      ifc.btn0 = 4'b1111; ifc.btn0_vld = 1'b0;
      checks++; if (ifc.core_btn !== 4'b1110) begin errors++; $display("FAIL sp_fwd: got %b expected %b", ifc.core_btn, 4'b1110); end
      tick();
      checks++; if (ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL sp_space: got %b expected %b", ifc.core_btn, 4'b1111); end
      checks++; if (ifc.drop !== 1'b0) begin errors++; $display("FAIL sp_drop: got %b expected %b", ifc.drop, 1'b0); end
      ifc.req = 2'b00;
      tick();
      checks++; if (ifc.gnt !== 2'b00) begin errors++; $display("FAIL sp_release: got %b expected %b", ifc.gnt, 2'b00); end
   endtask

   task automatic test_ignored_strobes;
      do_reset();
      ifc.req = 2'b01;
      tick();
      ifc.btn1 = 4'b1110; ifc.btn1_vld = 1'b1;
      tick();
      ifc.btn1 = 4'b1111; ifc.btn1_vld = 1'b0;
      checks++; if (ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL ign_other_btn: got %b expected %b", ifc.core_btn, 4'b1111); end
      checks++; if (ifc.drop !== 1'b0) begin errors++; $display("FAIL ign_other_drop: got %b expected %b", ifc.drop, 1'b0); end
      ifc.btn0 = 4'b1111; ifc.btn0_vld = 1'b1;
      tick();
      ifc.btn0_vld = 1'b0;
      checks++; if (ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL ign_none_btn: got %b expected %b", ifc.core_btn, 4'b1111); end
      tick();
      checks++; if (ifc.drop !== 1'b0) begin errors++; $display("FAIL ign_none_drop: got %b expected %b", ifc.drop, 1'b0); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      ifc.req = 2'b01;
      tick();
      ifc.btn0 = 4'b1101; ifc.btn0_vld = 1'b1;
      tick();
      checks++; if (ifc.core_btn !== 4'b1101) begin errors++; $display("FAIL b2b_first: got %b expected %b", ifc.core_btn, 4'b1101); end
      ifc.btn0 = 4'b1011;
      tick();
      ifc.btn0 = 4'b1111; ifc.btn0_vld = 1'b0;
      checks++; if (ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL b2b_second_btn: got %b expected %b", ifc.core_btn, 4'b1111); end
      checks++; if (ifc.drop !== 1'b1) begin errors++; $display("FAIL b2b_drop: got %b expected %b", ifc.drop, 1'b1); end
      tick();
      checks++; if (ifc.drop !== 1'b0) begin errors++; $display("FAIL b2b_drop_clear: got %b expected %b", ifc.drop, 1'b0); end
      ifc.btn0 = 4'b0111; ifc.btn0_vld = 1'b1;
      tick();
      ifc.btn0 = 4'b1111; ifc.btn0_vld = 1'b0;
      checks++; if (ifc.core_btn !== 4'b0111) begin errors++; $display("FAIL b2b_third: got %b expected %b", ifc.core_btn, 4'b0111); end
   endtask

   task automatic test_round_robin;
      do_reset();
      ifc.req = 2'b11;
      tick();
      checks++; if (ifc.gnt !== 2'b01) begin errors++; $display("FAIL rr_tie0: got %b expected %b", ifc.gnt, 2'b01); end
      ifc.req = 2'b10;
      tick();
      checks++; if (ifc.gnt !== 2'b00) begin errors++; $display("FAIL rr_release: got %b expected %b", ifc.gnt, 2'b00); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (ifc.gnt !== 2'b00 || ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL rr_gap%0d: got gnt=%b btn=%b expected gnt=00 btn=1111", i, ifc.gnt, ifc.core_btn); end
      end
      tick();
      checks++; if (ifc.gnt !== 2'b10) begin errors++; $display("FAIL rr_after_gap: got %b expected %b", ifc.gnt, 2'b10); end
      ifc.req = 2'b00;
      tick();
      ifc.req = 2'b11;
      for (int i = 0; i < 4; i++) tick();
      tick();
      checks++; if (ifc.gnt !== 2'b01) begin errors++; $display("FAIL rr_tie1: got %b expected %b", ifc.gnt, 2'b01); end
   endtask

   task automatic test_timeout;
      do_reset();
      ifc.req = 2'b01;
      tick();
      for (int i = 0; i < 7; i++) tick();
      checks++; if (ifc.gnt !== 2'b01 || ifc.timeout !== 1'b0) begin errors++; $display("FAIL to_last_cycle: got gnt=%b to=%b expected gnt=01 to=0", ifc.gnt, ifc.timeout); end
      tick();
      checks++; if (ifc.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected %b", ifc.timeout, 1'b1); end
      checks++; if (ifc.gnt !== 2'b00 || ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL to_outputs: got gnt=%b btn=%b expected gnt=00 btn=1111", ifc.gnt, ifc.core_btn); end
      tick();
      checks++; if (ifc.timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected %b", ifc.timeout, 1'b0); end
      // A press restarts the idle count.
      do_reset();
      ifc.req = 2'b01;
      tick();
      for (int i = 0; i < 5; i++) tick();
      ifc.btn0 = 4'b1110; ifc.btn0_vld = 1'b1;
      tick();
      ifc.btn0 = 4'b1111; ifc.btn0_vld = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checks++; if (ifc.gnt !== 2'b01 || ifc.timeout !== 1'b0) begin errors++; $display("FAIL to_restart_hold: got gnt=%b to=%b expected gnt=01 to=0", ifc.gnt, ifc.timeout); end
      tick();
      checks++; if (ifc.timeout !== 1'b1) begin errors++; $display("FAIL to_restart_pulse: got %b expected %b", ifc.timeout, 1'b1); end
   endtask

   task automatic test_locked;
      do_reset();
      ifc.core_locked = 1'b1;
      ifc.req = 2'b10;
      tick();
      tick();
      checks++; if (ifc.gnt !== 2'b00) begin errors++; $display("FAIL lk_no_grant: got %b expected %b", ifc.gnt, 2'b00); end
      ifc.core_locked = 1'b0;
      tick();
      checks++; if (ifc.gnt !== 2'b10) begin errors++; $display("FAIL lk_grant: got %b expected %b", ifc.gnt, 2'b10); end
      tick();
      ifc.core_locked = 1'b1;
      tick();
      checks++; if (ifc.gnt !== 2'b00) begin errors++; $display("FAIL lk_revoke: got %b expected %b", ifc.gnt, 2'b00); end
      checks++; if (ifc.timeout !== 1'b0) begin errors++; $display("FAIL lk_no_timeout: got %b expected %b", ifc.timeout, 1'b0); end
   endtask

   task automatic test_release_with_strobe;
      do_reset();
      ifc.req = 2'b01;
      tick();
      ifc.req = 2'b00;
      ifc.btn0 = 4'b1110; ifc.btn0_vld = 1'b1;
      tick();
      ifc.btn0 = 4'b1111; ifc.btn0_vld = 1'b0;
      checks++; if (ifc.gnt !== 2'b00) begin errors++; $display("FAIL rel_gnt: got %b expected %b", ifc.gnt, 2'b00); end
      checks++; if (ifc.drop !== 1'b1) begin errors++; $display("FAIL rel_drop: got %b expected %b", ifc.drop, 1'b1); end
      checks++; if (ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL rel_btn: got %b expected %b", ifc.core_btn, 4'b1111); end
   endtask

   task automatic test_ms;
      logic exp_remote;
`ifdef REMOTE_MS_EN
      exp_remote = 1'b1;
`else
      exp_remote = 1'b0;
`endif
      do_reset();
      ifc.req = 2'b10;
      ifc.ms_req = 2'b10;
      tick();
      checks++; if (ifc.gnt !== 2'b10) begin errors++; $display("FAIL ms_gnt1: got %b expected %b", ifc.gnt, 2'b10); end
      checks++; if (ifc.core_ms !== exp_remote) begin errors++; $display("FAIL ms_remote: got %b expected %b", ifc.core_ms, exp_remote); end
      do_reset();
      ifc.req = 2'b01;
      ifc.ms_req = 2'b01;
      tick();
      checks++; if (ifc.core_ms !== 1'b1) begin errors++; $display("FAIL ms_local: got %b expected %b", ifc.core_ms, 1'b1); end
      ifc.ms_req = 2'b00;
      tick();
      checks++; if (ifc.core_ms !== 1'b0) begin errors++; $display("FAIL ms_local_low: got %b expected %b", ifc.core_ms, 1'b0); end
      ifc.ms_req = 2'b01;
      ifc.req = 2'b00;
      tick();
      checks++; if (ifc.core_ms !== 1'b0) begin errors++; $display("FAIL ms_no_gnt: got %b expected %b", ifc.core_ms, 1'b0); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      ifc.req = 2'b01;
      ifc.ms_req = 2'b01;
      tick();
      ifc.btn0 = 4'b1110; ifc.btn0_vld = 1'b1;
      rst = 1'b1;
      tick();
      ifc.btn0 = 4'b1111; ifc.btn0_vld = 1'b0;
      checks++; if (ifc.core_btn !== 4'b1111 || ifc.gnt !== 2'b00) begin errors++; $display("FAIL rm_btn_gnt: got btn=%b gnt=%b expected btn=1111 gnt=00", ifc.core_btn, ifc.gnt); end
      checks++; if (ifc.core_ms !== 1'b0 || ifc.drop !== 1'b0 || ifc.timeout !== 1'b0) begin errors++; $display("FAIL rm_pulses: got ms=%b drop=%b to=%b expected 0 0 0", ifc.core_ms, ifc.drop, ifc.timeout); end
      rst = 1'b0;
      tick();
      checks++; if (ifc.gnt !== 2'b01 || ifc.core_btn !== 4'b1111) begin errors++; $display("FAIL rm_regrant: got gnt=%b btn=%b expected gnt=01 btn=1111", ifc.gnt, ifc.core_btn); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_single_press();
      test_ignored_strobes();
      test_back_to_back();
      test_round_robin();
      test_timeout();
      test_locked();
      test_release_with_strobe();
      test_ms();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
